seq_serializer: RTL and testbench

Parallel-to-serial stage that produces the single-bit serial stream consumed by the sequence detector. It accepts `DATA_W`-bit words over a valid/ready handshake, buffers one word, and shifts each word out one bit per clock. Back-to-back words stream with no idle gap, and the line rests at `IDLE_LEVEL` whenever no word is being shifted. The stream direction is selected per word.

---
 rtl/seq_serializer.sv | 112 +++++++++++
 tb/tb_seq_serializer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial stage feeding the sequence detector.
// Words arrive over valid/ready into a one-entry holding register and are
// shifted out one bit per clock, MSB- or LSB-first as chosen per word.
// Consecutive words stream with no idle gap; the line rests at IDLE_LEVEL.

module seq_serializer #(
    parameter int unsigned DATA_W     = 8,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_msb_first,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              serial_out,
    output logic              serial_valid,
    output logic              word_done,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    // Index of the bit currently on serial_out, and the one before it.
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(DATA_W - 2);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]        state;

    logic [DATA_W-1:0] hold_data;
    logic              hold_msb;
    logic              hold_full;

    logic [DATA_W-1:0] sh_data;
    logic              sh_msb;
    logic [CNT_W-1:0]  bit_cnt;

    logic              accept;
    logic              load;
    logic [DATA_W-1:0] sh_next;
    logic              first_bit;
    logic              next_bit;

    // Handshake, load decision and the next shifter contents.
    always_comb begin
        din_ready = ~hold_full & ~rst;
        accept    = din_valid & din_ready;
        load      = hold_full & ((state == S_IDLE) ||
                                 ((state == S_SHIFT) && (bit_cnt == LAST)));
        busy      = hold_full | (state == S_SHIFT);

        sh_next   = sh_msb ? {sh_data[DATA_W-2:0], 1'b0}
                           : {1'b0, sh_data[DATA_W-1:1]};
        next_bit  = sh_msb ? sh_next[DATA_W-1] : sh_next[0];
        first_bit = hold_msb ? hold_data[DATA_W-1] : hold_data[0];
    end

    // Holding register: filled on accept, emptied when the shifter loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data <= '0;
            hold_msb  <= 1'b0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_data <= din;
            hold_msb  <= din_msb_first;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // Shifter and FSM; serial outputs are registered so the bit index in
    // bit_cnt always matches what is on the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            sh_data      <= '0;
            sh_msb       <= 1'b0;
            bit_cnt      <= '0;
            serial_out   <= IDLE_LEVEL;
            serial_valid <= 1'b0;
            word_done    <= 1'b0;
        end else if (load) begin
            state        <= S_SHIFT;
            sh_data      <= hold_data;
            sh_msb       <= hold_msb;
            bit_cnt      <= '0;
            serial_out   <= first_bit;
            serial_valid <= 1'b1;
            word_done    <= 1'b0;
        end else if (state == S_SHIFT) begin
            if (bit_cnt == LAST) begin
                state        <= S_IDLE;
                bit_cnt      <= '0;
                serial_out   <= IDLE_LEVEL;
                serial_valid <= 1'b0;
                word_done    <= 1'b0;
            end else begin
                sh_data      <= sh_next;
                bit_cnt      <= bit_cnt + CNT_W'(1);
                serial_out   <= next_bit;
                serial_valid <= 1'b1;
                word_done    <= (bit_cnt == LAST_M1);
            end
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer (DATA_W = 8, IDLE_LEVEL = 1).

module tb_seq_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_msb_first;
    logic       din_valid;
    logic       din_ready;
    logic       serial_out;
    logic       serial_valid;
    logic       word_done;
    logic       busy;

    int total = 0;
    int bad   = 0;

    seq_serializer #(
        .DATA_W     (8),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .din           (din),
        .din_msb_first (din_msb_first),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .serial_out    (serial_out),
        .serial_valid  (serial_valid),
        .word_done     (word_done),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; samples happen 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst           = 1'b1;
        din           = 8'h00;
        din_msb_first = 1'b0;
        din_valid     = 1'b0;
        repeat (3) tick();
        total++; if (serial_out !== 1'b1) begin bad++; $display("FAIL reset_serial_out: got %b want 1", serial_out); end
        total++; if (serial_valid !== 1'b0) begin bad++; $display("FAIL reset_serial_valid: got %b want 0", serial_valid); end
        total++; if (word_done !== 1'b0) begin bad++; $display("FAIL reset_word_done: got %b want 0", word_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst: got %b want 0", din_ready); end
        rst = 1'b0;
        #1;
        total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b want 1", din_ready); end
        total++; if (serial_out !== 1'b1) begin bad++; $display("FAIL reset_idle_line: got %b want 1", serial_out); end
    endtask

    // seq[7] is the first bit expected on the line, seq[0] the last.
    task automatic test_single_word(input logic [7:0] d, input logic m,
                                    input logic [7:0] seq, input string nm);
        din           = d;
        din_msb_first = m;
        din_valid     = 1'b1;
        tick();
        din_valid     = 1'b0;
        din           = 8'h00;
        total++; if (serial_valid !== 1'b0) begin bad++; $display("FAIL %s_latency: serial_valid got %b want 0", nm, serial_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy_held: got %b want 1", nm, busy); end
        total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL %s_ready_held: got %b want 0", nm, din_ready); end
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (serial_out !== seq[7-i]) begin bad++; $display("FAIL %s_bit%0d: got %b want %b", nm, i, serial_out, seq[7-i]); end
            total++; if (serial_valid !== 1'b1) begin bad++; $display("FAIL %s_valid%0d: got %b want 1", nm, i, serial_valid); end
            total++; if (word_done !== (i == 7)) begin bad++; $display("FAIL %s_done%0d: got %b want %b", nm, i, word_done, (i == 7)); end
        end
        tick();
        total++; if (serial_out !== 1'b1) begin bad++; $display("FAIL %s_line_rest: got %b want 1", nm, serial_out); end
        total++; if (serial_valid !== 1'b0) begin bad++; $display("FAIL %s_valid_end: got %b want 0", nm, serial_valid); end
        total++; if (word_done !== 1'b0) begin bad++; $display("FAIL %s_done_end: got %b want 0", nm, word_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_end: got %b want 0", nm, busy); end
        total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_end: got %b want 1", nm, din_ready); end
    endtask

    // din_valid held high across 12, 34, 56 (MSB first). Accepts land on
    // edges 0, 2, 10; bits occupy edges 1..24; word_done on 8, 16, 24.
    task automatic test_back_to_back;
        logic [7:0]  words [3];
        logic [23:0] exp_bits;
        logic [23:0] got_bits;
        int          nxt;
        int          nbits;
        int          acc_c [3];
        logic        acc;
        logic        exp_ready;
        words    = '{8'h12, 8'h34, 8'h56};
        exp_bits = 24'h123456;
        got_bits = '0;
        nxt      = 0;
        nbits    = 0;
        acc_c    = '{-1, -1, -1};
        din           = words[0];
        din_msb_first = 1'b1;
        din_valid     = 1'b1;
        for (int c = 0; c < 28; c++) begin
            acc = din_valid && din_ready;
            tick();
            if (acc) begin
                acc_c[nxt] = c;
                nxt++;
                if (nxt < 3) din = words[nxt];
                else din_valid = 1'b0;
            end
            total++; if (serial_valid !== (c >= 1 && c <= 24)) begin bad++; $display("FAIL b2b_valid_c%0d: got %b want %b", c, serial_valid, (c >= 1 && c <= 24)); end
            total++; if (word_done !== (c == 8 || c == 16 || c == 24)) begin bad++; $display("FAIL b2b_done_c%0d: got %b want %b", c, word_done, (c == 8 || c == 16 || c == 24)); end
            exp_ready = (c == 1 || c == 9 || c >= 17);
            total++; if (din_ready !== exp_ready) begin bad++; $display("FAIL b2b_ready_c%0d: got %b want %b", c, din_ready, exp_ready); end
            if (serial_valid === 1'b1 && nbits < 24) begin
                got_bits = {got_bits[22:0], serial_out};
                nbits++;
            end
        end
        total++; if (nbits != 24) begin bad++; $display("FAIL b2b_bitcount: got %0d want 24", nbits); end
        total++; if (got_bits !== exp_bits) begin bad++; $display("FAIL b2b_stream: got %h want %h", got_bits, exp_bits); end
        total++; if (acc_c[0] != 0 || acc_c[1] != 2 || acc_c[2] != 10) begin bad++; $display("FAIL b2b_accept_cycles: got %0d,%0d,%0d want 0,2,10", acc_c[0], acc_c[1], acc_c[2]); end
    endtask

    // Third word offered while the holding register is full; it must wait
    // until the shifter loads word two (edge 9) and be taken on edge 10.
    task automatic test_backpressure;
        logic [7:0] words [3];
        logic       msbs  [3];
        logic [8:0] exp_q [$];
        logic [8:0] front;
        logic [7:0] cur;
        int         nbits;
        int         nwords;
        int         nxt;
        int         acc_c [3];
        logic       acc;
        words  = '{8'hA5, 8'h3C, 8'hE1};
        msbs   = '{1'b0, 1'b1, 1'b0};
        cur    = '0;
        nbits  = 0;
        nwords = 0;
        nxt    = 0;
        acc_c  = '{-1, -1, -1};
        din           = words[0];
        din_msb_first = msbs[0];
        din_valid     = 1'b1;
        for (int c = 0; c < 30; c++) begin
            acc = din_valid && din_ready;
            tick();
            if (acc) begin
                exp_q.push_back({din_msb_first, din});
                acc_c[nxt] = c;
                nxt++;
                if (nxt == 1) begin
                    din           = words[1];
                    din_msb_first = msbs[1];
                end else begin
                    din_valid = 1'b0;
                end
            end
            if (c >= 4 && c <= 8) begin
                total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c%0d: got %b want 0", c, din_ready); end
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy_c%0d: got %b want 1", c, busy); end
            end
            if (c == 4 && nxt == 2) begin
                din           = words[2];
                din_msb_first = msbs[2];
                din_valid     = 1'b1;
            end
            if (serial_valid === 1'b1) begin
                front = (exp_q.size() > 0) ? exp_q[0] : 9'h000;
                if (front[8]) cur = {cur[6:0], serial_out};
                else          cur = {serial_out, cur[7:1]};
                nbits++;
            end
            if (word_done === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL bp_extra_word: got %h want none", cur);
                end else begin
                    front = exp_q.pop_front();
                    if (cur !== front[7:0] || nbits != 8) begin
                        bad++; $display("FAIL bp_word%0d: got %h (%0d bits) want %h (8 bits)", nwords, cur, nbits, front[7:0]);
                    end
                end
                nwords++;
                nbits = 0;
            end
        end
        total++; if (nwords != 3) begin bad++; $display("FAIL bp_word_count: got %0d want 3", nwords); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); end
        total++; if (acc_c[0] != 0 || acc_c[1] != 2 || acc_c[2] != 10) begin bad++; $display("FAIL bp_accept_cycles: got %0d,%0d,%0d want 0,2,10", acc_c[0], acc_c[1], acc_c[2]); end
    endtask

    // Reset lands after the 4th bit of FF while 00 sits in the holding register.
    task automatic test_reset_mid_word;
        int seen_valid;
        int seen_done;
        seen_valid    = 0;
        seen_done     = 0;
        din           = 8'hFF;
        din_msb_first = 1'b1;
        din_valid     = 1'b1;
        tick();
        din           = 8'h00;
        din_msb_first = 1'b0;
        tick();
        tick();
        din_valid     = 1'b0;
        tick();
        tick();
        total++; if (serial_out !== 1'b1 || serial_valid !== 1'b1) begin bad++; $display("FAIL rmw_4th_bit: got out=%b valid=%b want 1 1", serial_out, serial_valid); end
        total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL rmw_hold_full: ready got %b want 0", din_ready); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (serial_valid !== 1'b0) begin bad++; $display("FAIL rmw_async_valid: got %b want 0", serial_valid); end
        total++; if (serial_out !== 1'b1) begin bad++; $display("FAIL rmw_async_out: got %b want 1", serial_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmw_async_busy: got %b want 0", busy); end
        total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL rmw_ready_in_rst: got %b want 0", din_ready); end
        repeat (2) begin
            tick();
            if (serial_valid !== 1'b0) seen_valid++;
            if (word_done !== 1'b0) seen_done++;
        end
        rst = 1'b0;
        repeat (12) begin
            tick();
            if (serial_valid !== 1'b0) seen_valid++;
            if (word_done !== 1'b0) seen_done++;
            if (busy !== 1'b0) seen_valid++;
        end
        total++; if (seen_valid != 0) begin bad++; $display("FAIL rmw_no_trailing_bits: got %0d active cycles want 0", seen_valid); end
        total++; if (seen_done != 0) begin bad++; $display("FAIL rmw_no_word_done: got %0d pulses want 0", seen_done); end
        total++; if (serial_out !== 1'b1 || din_ready !== 1'b1) begin bad++; $display("FAIL rmw_idle_after: got out=%b ready=%b want 1 1", serial_out, din_ready); end
    endtask

    initial begin
        test_reset();
        test_single_word(8'hB2, 1'b1, 8'b1011_0010, "msb_first");
        test_single_word(8'hB2, 1'b0, 8'b0100_1101, "lsb_first");
        test_back_to_back();
        tick();
        test_backpressure();
        tick();
        test_reset_mid_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
